tmds_soft_serializer: RTL and testbench

Vendor-neutral, parametrised parallel-to-serial converter for TMDS-style links. It runs entirely in the fast bit-clock domain and accepts one parallel word per channel through a valid/ready handshake. It emits BITS_PER_CLK bits per lane per cycle, for an external DDR/SDR output register, and generates an optional clock lane. It substitutes idle words on underrun and counts underruns.

---
 rtl/tmds_serial_pkg.sv | 17 +
 rtl/lane_shifter.sv | 45 ++++
 rtl/tmds_soft_serializer.sv | 114 +++++++++++
 tb/tb_tmds_soft_serializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tmds_serial_pkg.sv
// Shared constants and types for the TMDS soft serializer.
package tmds_serial_pkg;

    // TMDS control-period code words
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    localparam logic [9:0] TMDS_CLOCK_PATTERN = 10'b0000011111;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } serializer_state_t;

endpackage

// File: rtl/lane_shifter.sv
// One lane of the serializer: parallel load with optional bit reversal, then
// shift BITS_PER_CLK bits per cycle toward the output slice.
module lane_shifter #(
    parameter int unsigned WORD_WIDTH   = 10,
    parameter int unsigned BITS_PER_CLK = 2,
    parameter bit          REVERSE      = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [WORD_WIDTH-1:0]   word,
    output logic [BITS_PER_CLK-1:0] bits
);

    logic [WORD_WIDTH-1:0] shreg_q;
    logic [WORD_WIDTH-1:0] shreg_d;
    logic [WORD_WIDTH-1:0] load_word;

    always_comb begin
        load_word = word;
        if (REVERSE) begin
            for (int i = 0; i < int'(WORD_WIDTH); i++) begin
                load_word[i] = word[int'(WORD_WIDTH) - 1 - i];
            end
        end
    end

    always_comb begin
        shreg_d = shreg_q >> BITS_PER_CLK;
        if (load) begin
            shreg_d = load_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign bits = shreg_q[BITS_PER_CLK-1:0];

endmodule

// File: rtl/tmds_soft_serializer.sv
// Parallel-to-serial converter for TMDS-style links running in the bit-clock
// domain; substitutes idle words on underrun and counts underruns.
module tmds_soft_serializer
    import tmds_serial_pkg::*;
#(
    parameter int unsigned           NUM_CHANNELS  = 3,
    parameter int unsigned           WORD_WIDTH    = 10,
    parameter int unsigned           BITS_PER_CLK  = 2,
    parameter bit                    LSB_FIRST     = 1'b1,
    parameter bit                    CLOCK_LANE    = 1'b1,
    parameter logic [WORD_WIDTH-1:0] CLOCK_PATTERN = TMDS_CLOCK_PATTERN,
    parameter logic [WORD_WIDTH-1:0] IDLE_WORD     = TMDS_CTRL_00,
    parameter int unsigned           COUNT_WIDTH   = 16,
    localparam int unsigned          NUM_LANES     = NUM_CHANNELS + (CLOCK_LANE ? 1 : 0)
) (
    input  logic                              clk_pixel_x5,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [NUM_LANES*BITS_PER_CLK-1:0] lane_bits,
    output logic                              word_start,
    output logic                              underrun,
    output logic [COUNT_WIDTH-1:0]            underrun_count
);

    localparam int unsigned BEATS  = WORD_WIDTH / BITS_PER_CLK;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0]      beat_q, beat_d;
    serializer_state_t      state_q, state_d;
    logic                   word_start_q;
    logic                   underrun_q, underrun_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   load_edge;
    logic                   accept;

    assign load_edge = (beat_q == LAST_BEAT);
    // Gated by reset_n so no word is taken while the block is held in reset.
    assign s_ready   = reset_n && enable && load_edge;
    assign accept    = s_valid && s_ready;

    always_comb begin
        beat_d     = load_edge ? '0 : beat_q + 1'b1;
        state_d    = state_q;
        underrun_d = 1'b0;
        count_d    = count_q;
        if (load_edge) begin
            unique case (state_q)
                ST_OFF: begin
                    if (accept) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_d = ST_OFF;
                    end else if (!s_valid) begin
                        underrun_d = 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
        if (underrun_d && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel_x5) begin
        if (!reset_n) begin
            beat_q       <= LAST_BEAT;
            state_q      <= ST_OFF;
            word_start_q <= 1'b0;
            underrun_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            beat_q       <= beat_d;
            state_q      <= state_d;
            word_start_q <= load_edge;
            underrun_q   <= underrun_d;
            count_q      <= count_d;
        end
    end

    assign word_start     = word_start_q;
    assign underrun       = underrun_q;
    assign underrun_count = count_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [WORD_WIDTH-1:0] lane_word;

        if (l < NUM_CHANNELS) begin : g_data
            assign lane_word = accept ? s_data[l*WORD_WIDTH +: WORD_WIDTH] : IDLE_WORD;
        end else begin : g_clock
            assign lane_word = CLOCK_PATTERN;
        end

        lane_shifter #(
            .WORD_WIDTH   (WORD_WIDTH),
            .BITS_PER_CLK (BITS_PER_CLK),
            .REVERSE      (!LSB_FIRST)
        ) u_shifter (
            .clk     (clk_pixel_x5),
            .reset_n (reset_n),
            .load    (load_edge),
            .word    (lane_word),
            .bits    (lane_bits[l*BITS_PER_CLK +: BITS_PER_CLK])
        );
    end

endmodule

// File: tb/tb_tmds_soft_serializer.sv
// Directed, table-driven bench for tmds_soft_serializer; three instances share
// one stimulus stream (defaults, 4-bit counter, MSB-first).
module tb_tmds_soft_serializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [29:0] s_data;
    logic        s_valid;

    logic        s_ready, sat_ready, msb_ready;
    logic [7:0]  lane_bits, sat_lane_bits, msb_lane_bits;
    logic        word_start, sat_word_start, msb_word_start;
    logic        underrun, sat_underrun, msb_underrun;
    logic [15:0] underrun_count, msb_count;
    logic [3:0]  sat_count;

    int checks = 0;
    int errors = 0;
    int sat_pulses = 0;

    always #5 clk = ~clk;

    tmds_soft_serializer dut (
        .clk_pixel_x5   (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .lane_bits      (lane_bits),
        .word_start     (word_start),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    tmds_soft_serializer #(.COUNT_WIDTH(4)) dut_sat (
        .clk_pixel_x5   (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (sat_ready),
        .lane_bits      (sat_lane_bits),
        .word_start     (sat_word_start),
        .underrun       (sat_underrun),
        .underrun_count (sat_count)
    );

    tmds_soft_serializer #(.LSB_FIRST(1'b0)) dut_msb (
        .clk_pixel_x5   (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (msb_ready),
        .lane_bits      (msb_lane_bits),
        .word_start     (msb_word_start),
        .underrun       (msb_underrun),
        .underrun_count (msb_count)
    );

    always @(negedge clk) begin
        if (sat_underrun === 1'b1) sat_pulses++;
    end

    typedef struct {
        logic             en;
        logic             valid;
        logic [29:0]      data;
        logic             exp_ready;
        logic [0:4][7:0]  exp_lb;
        logic [0:4][1:0]  exp_msb0;
        logic             exp_ur;
        int               exp_cnt;
    } slot_t;

    // Words as {ch2, ch1, ch0}
    localparam logic [29:0] WA = {10'h2AA, 10'h000, 10'h3FF};
    localparam logic [29:0] WB = {10'h000, 10'h3FF, 10'h201};
    localparam logic [29:0] WC = {10'h3FF, 10'h000, 10'h300};

    // lane_bits per beat = {clk lane, ch2, ch1, ch0}
    localparam logic [0:4][7:0] LB_IDLE = {8'hC0, 8'hD5, 8'h55, 8'h15, 8'h3F};
    localparam logic [0:4][7:0] LB_A    = {8'hE3, 8'hE3, 8'h63, 8'h23, 8'h23};
    localparam logic [0:4][7:0] LB_B    = {8'hCD, 8'hCC, 8'h4C, 8'h0C, 8'h0E};
    localparam logic [0:4][7:0] LB_C    = {8'hF0, 8'hF0, 8'h70, 8'h30, 8'h33};

    // Channel-0 beats of the MSB-first instance
    localparam logic [0:4][1:0] M_IDLE = {2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
    localparam logic [0:4][1:0] M_A    = {2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    localparam logic [0:4][1:0] M_B    = {2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [0:4][1:0] M_C    = {2'b11, 2'b00, 2'b00, 2'b00, 2'b00};

    slot_t tbl [11];

    function automatic slot_t mk(input logic en, input logic valid, input logic [29:0] data,
                                 input logic rdy, input logic [0:4][7:0] lb,
                                 input logic [0:4][1:0] m0, input logic ur, input int cnt);
        slot_t s;
        s.en = en; s.valid = valid; s.data = data; s.exp_ready = rdy;
        s.exp_lb = lb; s.exp_msb0 = m0; s.exp_ur = ur; s.exp_cnt = cnt;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called in the pre-load cycle; returns in the last-beat cycle of the slot.
    task automatic run_slot(input slot_t r, input string tag);
        int sat_exp;
        sat_exp = (r.exp_cnt > 15) ? 15 : r.exp_cnt;
        enable  = r.en;
        s_valid = r.valid;
        s_data  = r.data;
        #1;
        chk({tag, " s_ready"}, 32'(s_ready), 32'(r.exp_ready));
        for (int b = 0; b < 5; b++) begin
            @(posedge clk);
            #1;
            chk({tag, " lane_bits"}, 32'(lane_bits), 32'(r.exp_lb[b]));
            chk({tag, " msb ch0"}, 32'(msb_lane_bits[1:0]), 32'(r.exp_msb0[b]));
            chk({tag, " word_start"}, 32'(word_start), (b == 0) ? 32'd1 : 32'd0);
            chk({tag, " underrun"}, 32'(underrun), (b == 0) ? 32'(r.exp_ur) : 32'd0);
            chk({tag, " count"}, 32'(underrun_count), 32'(r.exp_cnt));
            chk({tag, " sat count"}, 32'(sat_count), 32'(sat_exp));
            if (b < 4) chk({tag, " s_ready mid"}, 32'(s_ready), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int pulses_before;
        slot_t s;

        tbl[0]  = mk(1'b0, 1'b0, 30'h0, 1'b0, LB_IDLE, M_IDLE, 1'b0, 0);
        tbl[1]  = mk(1'b0, 1'b1, WA,    1'b0, LB_IDLE, M_IDLE, 1'b0, 0);
        tbl[2]  = mk(1'b1, 1'b0, 30'h0, 1'b1, LB_IDLE, M_IDLE, 1'b0, 0);
        tbl[3]  = mk(1'b1, 1'b1, WA,    1'b1, LB_A,    M_A,    1'b0, 0);
        tbl[4]  = mk(1'b1, 1'b1, WA,    1'b1, LB_A,    M_A,    1'b0, 0);
        tbl[5]  = mk(1'b1, 1'b0, 30'h0, 1'b1, LB_IDLE, M_IDLE, 1'b1, 1);
        tbl[6]  = mk(1'b1, 1'b1, WB,    1'b1, LB_B,    M_B,    1'b0, 1);
        tbl[7]  = mk(1'b1, 1'b1, WC,    1'b1, LB_C,    M_C,    1'b0, 1);
        tbl[8]  = mk(1'b0, 1'b1, WC,    1'b0, LB_IDLE, M_IDLE, 1'b0, 1);
        tbl[9]  = mk(1'b1, 1'b0, 30'h0, 1'b1, LB_IDLE, M_IDLE, 1'b0, 1);
        tbl[10] = mk(1'b1, 1'b1, WA,    1'b1, LB_A,    M_A,    1'b0, 1);

        // Reset with inputs requesting data: nothing may be accepted.
        reset_n = 1'b0;
        enable  = 1'b1;
        s_valid = 1'b1;
        s_data  = WA;
        repeat (3) @(posedge clk);
        #1;
        chk("reset s_ready", 32'(s_ready), 32'd0);
        chk("reset lane_bits", 32'(lane_bits), 32'd0);
        chk("reset word_start", 32'(word_start), 32'd0);
        chk("reset underrun", 32'(underrun), 32'd0);
        chk("reset count", 32'(underrun_count), 32'd0);
        enable  = 1'b0;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_slot(tbl[i], $sformatf("slot%0d", i));
        end

        // 20 consecutive underruns in RUN; the 4-bit counter must stick at 15.
        pulses_before = sat_pulses;
        for (int i = 0; i < 20; i++) begin
            s = mk(1'b1, 1'b0, 30'h0, 1'b1, LB_IDLE, M_IDLE, 1'b1, 2 + i);
            run_slot(s, $sformatf("urun%0d", i));
        end
        chk("sat underrun pulses", 32'(sat_pulses - pulses_before), 32'd20);
        run_slot(mk(1'b1, 1'b1, WB, 1'b1, LB_B, M_B, 1'b0, 21), "resume");

        // Reset in the middle of a word.
        enable  = 1'b1;
        s_valid = 1'b1;
        s_data  = WA;
        #1;
        chk("mid s_ready", 32'(s_ready), 32'd1);
        for (int b = 0; b < 3; b++) begin
            @(posedge clk);
            #1;
            chk("mid beat", 32'(lane_bits), 32'(LB_A[b]));
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid reset lane_bits", 32'(lane_bits), 32'd0);
        chk("mid reset word_start", 32'(word_start), 32'd0);
        chk("mid reset underrun", 32'(underrun), 32'd0);
        chk("mid reset count", 32'(underrun_count), 32'd0);
        chk("mid reset sat count", 32'(sat_count), 32'd0);
        chk("mid reset s_ready", 32'(s_ready), 32'd0);
        reset_n = 1'b1;
        // Back in OFF: a missing word must not count as underrun.
        run_slot(mk(1'b1, 1'b0, 30'h0, 1'b1, LB_IDLE, M_IDLE, 1'b0, 0), "post off");
        run_slot(mk(1'b1, 1'b1, WC, 1'b1, LB_C, M_C, 1'b0, 0), "post data");
        run_slot(mk(1'b1, 1'b0, 30'h0, 1'b1, LB_IDLE, M_IDLE, 1'b1, 1), "post urun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
